irq_ctrl: RTL and testbench



---
 rtl/irq_ctrl.sv | 124 ++++++++++++
 tb/tb_irq_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: multi-channel interrupt controller on the core's IO port.
// Latches per-channel edge/level pending state, masks it with per-channel
// and global enables, and drives a single registered irq to the core.
// Software services it through a 16-byte window: PENDING, ENABLE, CLAIM, CTRL.
module irq_ctrl #(
    parameter int                 NUM_IRQ   = 8,
    parameter logic [15:0]        BASE_ADDR = 16'h0100,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = {NUM_IRQ{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               io_r,
    input  logic               io_w,
    input  logic [15:0]        io_addr,
    input  logic [31:0]        io_wdata,
    output logic [31:0]        io_rdata,
    output logic               irq
);

    localparam logic [1:0] REG_PEND  = 2'd0;
    localparam logic [1:0] REG_EN    = 2'd1;
    localparam logic [1:0] REG_CLAIM = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    logic [NUM_IRQ-1:0] src_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] en_q,   en_d;
    logic               gen_q,  gen_d;
    logic               irq_q,  irq_d;

    logic               sel;
    logic [1:0]         idx;
    logic               rd_hit, wr_hit;
    logic [NUM_IRQ-1:0] active;
    logic [31:0]        claim_id;
    logic [NUM_IRQ-1:0] claim_oh;
    logic [NUM_IRQ-1:0] clr_mask;

    // Byte-lane bits of the address and the write-data bits above NUM_IRQ
    // carry no meaning here; fold them into a sink so they are visibly unused.
    logic unused_bits;
    assign unused_bits = ^{io_wdata, io_addr[1:0]};

    assign sel    = (io_addr[15:4] == BASE_ADDR[15:4]);
    assign idx    = io_addr[3:2];
    assign rd_hit = io_r & sel;
    assign wr_hit = io_w & sel;
    assign active = pend_q & en_q;

    // Lowest active channel wins the claim; scanning high-to-low lets the
    // last hit (lowest index) overwrite earlier ones. Global disable hides all.
    always_comb begin
        claim_id = 32'hFFFF_FFFF;
        claim_oh = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                claim_id    = 32'(i);
                claim_oh    = '0;
                claim_oh[i] = 1'b1;
            end
        end
        if (!gen_q) begin
            claim_id = 32'hFFFF_FFFF;
            claim_oh = '0;
        end
    end

    // Combinational read mux; returns pre-write values when read and write coincide.
    always_comb begin
        io_rdata = 32'd0;
        if (rd_hit) begin
            case (idx)
                REG_PEND:  io_rdata = 32'(pend_q);
                REG_EN:    io_rdata = 32'(en_q);
                REG_CLAIM: io_rdata = claim_id;
                REG_CTRL:  io_rdata = {31'd0, gen_q};
                default:   io_rdata = 32'd0;
            endcase
        end
    end

    // Next-state: W1C and claim clear edge channels, a new rising edge
    // re-sets on top of any clear, level channels simply follow the source.
    always_comb begin
        clr_mask = '0;
        if (wr_hit && idx == REG_PEND)
            clr_mask = clr_mask | io_wdata[NUM_IRQ-1:0];
        if (rd_hit && idx == REG_CLAIM)
            clr_mask = clr_mask | claim_oh;

        pend_d = (EDGE_MASK & ((pend_q & ~clr_mask) | (irq_src & ~src_q)))
               | (~EDGE_MASK & irq_src);

        en_d  = en_q;
        gen_d = gen_q;
        if (wr_hit && idx == REG_EN)
            en_d = io_wdata[NUM_IRQ-1:0];
        if (wr_hit && idx == REG_CTRL)
            gen_d = io_wdata[0];

        irq_d = gen_q & (|active);
    end

    // State registers; the source sampler keeps tracking during reset so a
    // line held high across reset is not mistaken for a fresh edge.
    always_ff @(posedge clk) begin
        src_q <= irq_src;
        if (rst) begin
            pend_q <= '0;
            en_q   <= '0;
            gen_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            en_q   <= en_d;
            gen_q  <= gen_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed vectors with hand-computed expectations for irq_ctrl.
// Channel 5 is level-type, all others edge-type.
module tb_irq_ctrl;

    localparam int          N    = 8;
    localparam logic [15:0] BASE = 16'h0100;
    localparam logic [15:0] A_PEND  = BASE + 16'h0;
    localparam logic [15:0] A_EN    = BASE + 16'h4;
    localparam logic [15:0] A_CLAIM = BASE + 16'h8;
    localparam logic [15:0] A_CTRL  = BASE + 16'hC;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq_src;
    logic         io_r, io_w;
    logic [15:0]  io_addr;
    logic [31:0]  io_wdata;
    logic [31:0]  io_rdata;
    logic         irq;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] d;

    irq_ctrl #(
        .NUM_IRQ  (N),
        .BASE_ADDR(BASE),
        .EDGE_MASK(8'hDF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .io_r    (io_r),
        .io_w    (io_w),
        .io_addr (io_addr),
        .io_wdata(io_wdata),
        .io_rdata(io_rdata),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] v);
        io_w = 1'b1; io_addr = a; io_wdata = v;
        tick();
        io_w = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] v);
        io_r = 1'b1; io_addr = a;
        #1 v = io_rdata;
        tick();
        io_r = 1'b0;
    endtask

    task automatic rw(input logic [15:0] a, input logic [31:0] wv, output logic [31:0] v);
        io_r = 1'b1; io_w = 1'b1; io_addr = a; io_wdata = wv;
        #1 v = io_rdata;
        tick();
        io_r = 1'b0; io_w = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_src = '0; io_r = 1'b0; io_w = 1'b0;
        io_addr = 16'h0; io_wdata = 32'h0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_irq", {31'd0, irq}, 32'd0);
        io_addr = A_EN;
        #1 chk("idle_rdata", io_rdata, 32'd0);
        rd(A_PEND, d); chk("rst_pend", d, 32'd0);
        rd(A_EN,   d); chk("rst_en",   d, 32'd0);
        rd(A_CTRL, d); chk("rst_ctrl", d, 32'd0);

        // single edge pulse on channel 2, claim it
        wr(A_EN, 32'h05);
        wr(A_CTRL, 32'h1);
        irq_src = 8'h04; tick(); irq_src = '0;
        chk("t1_irq_lag", {31'd0, irq}, 32'd0);
        rd(A_PEND, d);  chk("t1_pend", d, 32'h04);
        chk("t1_irq_hi", {31'd0, irq}, 32'd1);
        rd(A_CLAIM, d); chk("t1_claim", d, 32'd2);
        chk("t1_irq_lag2", {31'd0, irq}, 32'd1);
        rd(A_PEND, d);  chk("t1_pend_clr", d, 32'h0);
        chk("t1_irq_lo", {31'd0, irq}, 32'd0);

        // two edge channels, priority order
        wr(A_EN, 32'h09);
        irq_src = 8'h09; tick(); irq_src = '0; tick();
        chk("t2_irq_hi", {31'd0, irq}, 32'd1);
        rd(A_CLAIM, d); chk("t2_claim0", d, 32'd0);
        rd(A_CLAIM, d); chk("t2_claim3", d, 32'd3);
        rd(A_CLAIM, d); chk("t2_claim_none", d, 32'hFFFF_FFFF);
        chk("t2_irq_lo", {31'd0, irq}, 32'd0);

        // level channel 5
        wr(A_EN, 32'h20);
        irq_src = 8'h20; tick(); tick();
        chk("t3_irq_hi", {31'd0, irq}, 32'd1);
        wr(A_PEND, 32'h20);
        rd(A_PEND, d);  chk("t3_w1c_noeff", d, 32'h20);
        rd(A_CLAIM, d); chk("t3_claim5a", d, 32'd5);
        rd(A_CLAIM, d); chk("t3_claim5b", d, 32'd5);
        irq_src = '0; tick();
        chk("t3_irq_lag", {31'd0, irq}, 32'd1);
        rd(A_PEND, d);  chk("t3_pend_lo", d, 32'h0);
        chk("t3_irq_lo", {31'd0, irq}, 32'd0);

        // rising edge coincides with W1C: set wins
        wr(A_EN, 32'h02);
        irq_src = 8'h02; tick(); irq_src = '0; tick();
        irq_src = 8'h02; wr(A_PEND, 32'h02); irq_src = '0;
        rd(A_PEND, d); chk("t4_set_wins", d, 32'h02);
        wr(A_PEND, 32'h02);
        rd(A_PEND, d); chk("t4_w1c", d, 32'h00);

        // global disable masks irq and claim, keeps pending
        wr(A_CTRL, 32'h0);
        irq_src = 8'h02; tick(); irq_src = '0; tick(); tick();
        chk("t5_irq_off", {31'd0, irq}, 32'd0);
        rd(A_CLAIM, d); chk("t5_claim_off", d, 32'hFFFF_FFFF);
        rd(A_PEND, d);  chk("t5_pend_kept", d, 32'h02);

        // bits above NUM_IRQ, simultaneous read/write, unselected window
        wr(A_EN, 32'hFFFF_FFFF);
        rd(A_EN, d); chk("t6_en_width", d, 32'hFF);
        rw(A_EN, 32'h0F, d); chk("t6_rw_old", d, 32'hFF);
        rd(A_EN, d); chk("t6_rw_new", d, 32'h0F);
        wr(BASE + 16'h10, 32'hFFFF_FFFF);
        rd(A_EN, d);   chk("t6_unsel_en", d, 32'h0F);
        rd(A_CTRL, d); chk("t6_unsel_ctrl", d, 32'h0);
        rd(A_PEND, d); chk("t6_unsel_pend", d, 32'h02);
        rd(BASE + 16'h10, d); chk("t6_unsel_rd", d, 32'h0);

        // source held high through reset produces no edge
        irq_src = 8'h01; rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
        rd(A_PEND, d); chk("t7_pend", d, 32'h0);
        rd(A_EN, d);   chk("t7_en", d, 32'h0);
        chk("t7_irq", {31'd0, irq}, 32'd0);
        irq_src = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
